srio_chan_arb: RTL and testbench
================================

Name: srio_chan_arb

Overview:
Round-robin scheduler that shares the single 64-bit SRIO transmit stream between the three DDC channel FIFOs (he, fw, fy).
- Each grant emits one packet: a header word followed by a fixed burst of FIFO words.
- Sits between the per-channel FWFT FIFOs, written on the 100 MHz DDC side, and the SRIO packet builder.
- Frame numbering is aligned to the radar PRI pulse.

Parameters:
BURST_LEN, 32, data words per packet (1..4095)
CNT_W, 10, width of each FIFO fill-count input
HDR_TAG, 8'hA5, constant tag in header bits [63:56]

Ports:
clk_100M  in  1  system clock, 100 MHz
rst_n  in  1  asynchronous reset, active-low
PRI  in  1  PRI pulse, level, synchronous to clk_100M
ch_cnt  in  3*CNT_W  FIFO fill levels; ch0=he [CNT_W-1:0], ch1=fw, ch2=fy
ch_dout  in  3*64  FWFT FIFO head words, ch0 in [63:0]
ch_rd_en  out  3  one-hot FIFO pop
tx_data  out  64  packet word
tx_valid  out  1  word valid
tx_ready  in  1  downstream accept
tx_sop  out  1  header word marker
tx_eop  out  1  last word of packet
tx_ch  out  2  channel of the current packet
frame_no  out  16  PRI frame counter

Behaviour:
- Reset: all outputs 0, state IDLE, rr_ptr=0, seq=0, frame_no=0.
- PRI rising edge (registered PRI vs current PRI):
  - frame_no <= frame_no+1 (wraps at 16'hFFFF->0).
  - seq <= 0.
  - Takes effect 1 cycle after the edge and never aborts a packet in flight.
- Transfer occurs only when tx_valid && tx_ready. tx_data and tx_ch hold while tx_valid && !tx_ready.
- Eligibility: channel k is eligible when ch_cnt[k] >= BURST_LEN.
- IDLE: go to ARB next cycle.
- ARB:
  - Search eligible channels starting at rr_ptr, in order rr_ptr, rr_ptr+1, rr_ptr+2 (mod 3).
  - First hit: latch sel, load word counter, go to HDR.
  - No hit: stay in ARB.
- HDR:
  - tx_valid=1, tx_sop=1.
  - tx_data = {HDR_TAG, 2'b00, sel[1:0], len[11:0], frame_no[15:0], seq[23:0]}, len=BURST_LEN.
  - On transfer go to DATA.
- DATA:
  - tx_valid=1, tx_data=ch_dout[sel] (combinational), ch_rd_en[sel]=tx_ready.
  - Word counter decrements per transfer.
  - tx_eop=1 on the last word.
  - On the eop transfer: rr_ptr <= sel+1 (mod 3), seq <= seq+1 (wraps at 24 bits), go to ARB.
  - This gives a minimum 1 idle cycle between packets.
- Latency: eligible channel in ARB -> header presented the next cycle. A packet with tx_ready held high occupies BURST_LEN+1 consecutive cycles.
- Simultaneous events:
  - PRI edge on the same cycle as an eop transfer: seq is reset to 0 (PRI wins over increment).
  - Header of the next packet carries the new frame_no.
- ch_rd_en is never asserted outside DATA and never to more than one FIFO. The FIFO is never popped when tx_ready=0.
- ch_cnt is sampled only in ARB. Counts below BURST_LEN never start a packet, so no underflow is possible.
- rst_n asserted mid-packet: immediate return to reset values. The partial packet is dropped and the downstream builder discards it on missing eop.

Optional Feature:
PARTIAL_FLUSH_EN
- Defined:
  - A PRI rising edge arms a per-channel flush flag for every channel with 0 < ch_cnt < BURST_LEN at that cycle.
  - In ARB, a flagged channel is eligible with len = its ch_cnt sampled in ARB.
  - Full-burst channels and flagged channels share the same round-robin order.
  - The flag clears on that packet's eop.
  - tx_eop asserts after len words.
- Undefined: no flags exist, and residual words wait for the next fill.

Test Plan:
- BURST_LEN=32, ch_cnt={40,40,40}, tx_ready=1 -> packets in order ch0, ch1, ch2, ch0; each is 33 cycles with 1 gap cycle; header seq=0,1,2,3; 32 ch_rd_en pulses each.
- Only ch2 count=32, rr_ptr=0 -> ch2 granted; header tx_data[53:52]=2'b10, len=12'd32.
- tx_ready toggled 1/0 every cycle during DATA -> tx_data stable while stalled; exactly 32 pops; eop on 32nd accepted word.
- PRI edge during a ch1 burst -> burst completes unchanged; next header has frame_no+1 and seq=0; PRI edge coincident with eop -> seq=0.
- rst_n low at data word 10 -> all outputs 0 within same cycle (async); after release, first header has seq=0, frame_no=0.
- PARTIAL_FLUSH_EN, ch0 cnt=5 at PRI edge, others 0 -> 6-word packet, len=12'd5, eop on 5th data word, flag cleared.

Source files
------------

// File: rtl/srio_chan_arb.sv
// Round-robin scheduler sharing one 64-bit SRIO transmit stream between the he/fw/fy DDC FIFOs.
// Optional build macro PARTIAL_FLUSH_EN: a PRI edge lets partially filled FIFOs send a short packet.
module srio_chan_arb #(
    parameter int unsigned BURST_LEN = 32,
    parameter int unsigned CNT_W     = 10,
    parameter logic [7:0]  HDR_TAG   = 8'hA5
) (
    input  logic                 clk_100M,
    input  logic                 rst_n,
    input  logic                 PRI,
    input  logic [3*CNT_W-1:0]   ch_cnt,
    input  logic [3*64-1:0]      ch_dout,
    output logic [2:0]           ch_rd_en,
    output logic [63:0]          tx_data,
    output logic                 tx_valid,
    input  logic                 tx_ready,
    output logic                 tx_sop,
    output logic                 tx_eop,
    output logic [1:0]           tx_ch,
    output logic [15:0]          frame_no
);

    localparam logic [1:0]  S_IDLE   = 2'd0;
    localparam logic [1:0]  S_ARB    = 2'd1;
    localparam logic [1:0]  S_HDR    = 2'd2;
    localparam logic [1:0]  S_DATA   = 2'd3;
    localparam logic [11:0] FULL_LEN = 12'(BURST_LEN);

    logic [1:0]       state;
    logic [1:0]       rr_ptr;
    logic [1:0]       sel;
    logic [11:0]      word_cnt;
    logic [23:0]      seq;
    logic             seq_clr_pend;
    logic             pri_q;
    logic [63:0]      hdr_word;

    logic             pri_rise;
    logic             eop_xfer;
    logic [CNT_W-1:0] cnt [3];
    logic [2:0]       elig;
    logic [11:0]      ch_len [3];
    logic             hit;
    logic [1:0]       pick;
    logic [11:0]      pick_len;
    logic [23:0]      seq_nxt;
    logic [15:0]      frame_nxt;

`ifdef PARTIAL_FLUSH_EN
    logic [2:0]       flush_flag;
    logic [2:0]       flush_arm;
    logic [2:0]       flush_clr;
`endif

    // Modulo-3 channel increment; c and d are both in 0..2.
    function automatic logic [1:0] ch_add(input logic [1:0] c, input logic [1:0] d);
        logic [2:0] s;
        logic [2:0] r;
        s = {1'b0, c} + {1'b0, d};
        r = s - 3'd3;
        return (s >= 3'd3) ? r[1:0] : s[1:0];
    endfunction

    assign pri_rise = PRI & ~pri_q;
    assign eop_xfer = (state == S_DATA) && tx_ready && (word_cnt == 12'd1);

    always_comb begin
        for (int k = 0; k < 3; k++) begin
            cnt[k] = ch_cnt[k*CNT_W +: CNT_W];
        end
    end

    always_comb begin
        // NOTE: every combinational output gets a default before any branch, so no latch is inferred.
        for (int k = 0; k < 3; k++) begin
            elig[k]   = (32'(cnt[k]) >= BURST_LEN);
            ch_len[k] = FULL_LEN;
`ifdef PARTIAL_FLUSH_EN
            if (!elig[k] && flush_flag[k] && (cnt[k] != '0)) begin
                elig[k]   = 1'b1;
                ch_len[k] = 12'(cnt[k]);
            end
`endif
        end
    end

    // Walk the search order backwards so the channel closest to rr_ptr wins.
    always_comb begin
        hit      = 1'b0;
        pick     = rr_ptr;
        pick_len = FULL_LEN;
        for (int i = 2; i >= 0; i--) begin
            for (int k = 0; k < 3; k++) begin
                if ((k == int'(ch_add(rr_ptr, 2'(i)))) && elig[k]) begin
                    hit      = 1'b1;
                    pick     = 2'(k);
                    pick_len = ch_len[k];
                end
            end
        end
    end

    // A PRI edge inside a packet is remembered so the eop increment cannot undo the seq clear.
    always_comb begin
        frame_nxt = pri_rise ? (frame_no + 16'd1) : frame_no;
        seq_nxt   = seq;
        if (pri_rise) begin
            seq_nxt = '0;
        end else if (eop_xfer) begin
            seq_nxt = seq_clr_pend ? 24'd0 : (seq + 24'd1);
        end
    end

    always_ff @(posedge clk_100M or negedge rst_n) begin
        if (!rst_n) begin
            state        <= S_IDLE;
            rr_ptr       <= '0;
            sel          <= '0;
            word_cnt     <= '0;
            seq          <= '0;
            seq_clr_pend <= 1'b0;
            pri_q        <= 1'b0;
            hdr_word     <= '0;
            frame_no     <= '0;
        end else begin
            // NOTE: non-blocking assignments keep every register update based on pre-edge values.
            pri_q    <= PRI;
            frame_no <= frame_nxt;
            seq      <= seq_nxt;

            if (eop_xfer) begin
                seq_clr_pend <= 1'b0;
            end else if (pri_rise && ((state == S_HDR) || (state == S_DATA))) begin
                seq_clr_pend <= 1'b1;
            end

            case (state)
                S_IDLE: state <= S_ARB;
                S_ARB: begin
                    if (hit) begin
                        sel      <= pick;
                        word_cnt <= pick_len;
                        hdr_word <= {HDR_TAG, 2'b00, pick, pick_len, frame_nxt, seq_nxt};
                        state    <= S_HDR;
                    end
                end
                S_HDR: begin
                    if (tx_ready) state <= S_DATA;
                end
                default: begin
                    if (tx_ready) begin
                        word_cnt <= word_cnt - 12'd1;
                        if (word_cnt == 12'd1) begin
                            rr_ptr <= ch_add(sel, 2'd1);
                            state  <= S_ARB;
                        end
                    end
                end
            endcase
        end
    end

`ifdef PARTIAL_FLUSH_EN
    always_comb begin
        flush_clr = '0;
        for (int k = 0; k < 3; k++) begin
            flush_arm[k] = pri_rise && (cnt[k] != '0) && (32'(cnt[k]) < BURST_LEN);
            if (eop_xfer && (sel == 2'(k))) flush_clr[k] = 1'b1;
        end
    end

    always_ff @(posedge clk_100M or negedge rst_n) begin
        if (!rst_n) begin
            flush_flag <= '0;
        end else begin
            flush_flag <= (flush_flag & ~flush_clr) | flush_arm;
        end
    end
`endif

    // Header is held in a register so it stays stable while the downstream stalls.
    always_comb begin
        tx_valid = (state == S_HDR) || (state == S_DATA);
        tx_sop   = (state == S_HDR);
        tx_eop   = (state == S_DATA) && (word_cnt == 12'd1);
        tx_data  = '0;
        ch_rd_en = '0;
        if (state == S_HDR) begin
            tx_data = hdr_word;
        end else if (state == S_DATA) begin
            case (sel)
                2'd0:    tx_data = ch_dout[63:0];
                2'd1:    tx_data = ch_dout[127:64];
                default: tx_data = ch_dout[191:128];
            endcase
            if (tx_ready) ch_rd_en = 3'b001 << sel;
        end
    end

    assign tx_ch = sel;

endmodule

// File: tb/tb_srio_chan_arb.sv
// Directed self-checking bench for srio_chan_arb: round-robin order, stalls, PRI framing and reset.
module tb_srio_chan_arb;

    localparam int BL = 32;

    logic          clk_100M = 1'b0;
    logic          rst_n;
    logic          PRI;
    logic          tx_ready;
    logic [9:0]    cnt [3];
    logic [29:0]   ch_cnt;
    logic [191:0]  ch_dout;
    logic [2:0]    ch_rd_en;
    logic [63:0]   tx_data;
    logic          tx_valid;
    logic          tx_sop;
    logic          tx_eop;
    logic [1:0]    tx_ch;
    logic [15:0]   frame_no;

    logic [15:0]   head [3] = '{16'd0, 16'd0, 16'd0};
    int            exp_head [3];
    logic          toggle;
    int            n_cmp;
    int            n_bad;

    always #5 clk_100M = ~clk_100M;

    srio_chan_arb #(.BURST_LEN(BL), .CNT_W(10), .HDR_TAG(8'hA5)) dut (
        .clk_100M (clk_100M),
        .rst_n    (rst_n),
        .PRI      (PRI),
        .ch_cnt   (ch_cnt),
        .ch_dout  (ch_dout),
        .ch_rd_en (ch_rd_en),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready),
        .tx_sop   (tx_sop),
        .tx_eop   (tx_eop),
        .tx_ch    (tx_ch),
        .frame_no (frame_no)
    );

    function automatic logic [63:0] fifo_word(input logic [1:0] k, input logic [15:0] h);
        return {8'hD0, 6'd0, k, 32'h0, h};
    endfunction

    function automatic logic [63:0] hdr_exp(input logic [1:0] ch, input logic [11:0] len,
                                            input logic [15:0] fr, input logic [23:0] sq);
        return {8'hA5, 2'b00, ch, len, fr, sq};
    endfunction

    // Each FIFO head advances when popped; fill levels are held by the stimulus.
    assign ch_cnt  = {cnt[2], cnt[1], cnt[0]};
    assign ch_dout = {fifo_word(2'd2, head[2]), fifo_word(2'd1, head[1]), fifo_word(2'd0, head[0])};

    always @(posedge clk_100M) begin
        for (int k = 0; k < 3; k++) begin
            if (ch_rd_en[k]) head[k] <= head[k] + 16'd1;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout, required $finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_100M);
        #1;
        PRI = 1'b0;
        if (toggle) tx_ready = ~tx_ready;
        @(negedge clk_100M);
    endtask

    task automatic reset_checks(input string pfx);
        chk({pfx, "_valid"}, tx_valid, 1'b0);
        chk({pfx, "_data"},  tx_data,  64'd0);
        chk({pfx, "_rd_en"}, ch_rd_en, 3'b000);
        chk({pfx, "_sop"},   tx_sop,   1'b0);
        chk({pfx, "_eop"},   tx_eop,   1'b0);
        chk({pfx, "_ch"},    tx_ch,    2'd0);
        chk({pfx, "_frame"}, frame_no, 16'd0);
    endtask

    task automatic wait_sop(input int max_cyc, output int n);
        n = 0;
        while (!tx_sop && n < max_cyc) begin
            step();
            n++;
        end
        chk("sop_seen", tx_sop, 1'b1);
    endtask

    // Called at the negedge where the header is presented; returns in the gap cycle after eop.
    task automatic run_pkt(input logic [1:0] ch, input int len, input logic [15:0] fr,
                           input logic [23:0] sq, input int pri_at, input int rst_at);
        int          beat;
        int          bad;
        int          guard;
        logic        stalled;
        logic        pri_done;
        logic [63:0] prev;
        logic [15:0] head0;
        logic [63:0] hdr;
        hdr      = hdr_exp(ch, 12'(len), fr, sq);
        head0    = head[ch];
        beat     = 0;
        bad      = 0;
        guard    = 0;
        stalled  = 1'b0;
        pri_done = 1'b0;
        prev     = '0;
        chk("hdr_data", tx_data, hdr);
        chk("hdr_ch",   tx_ch,   ch);
        while (beat < len && guard < 4*len + 20) begin
            guard++;
            if (rst_at >= 0 && beat == rst_at && !tx_sop) begin
                rst_n = 1'b0;
                #1;
                reset_checks("midpkt_rst");
                return;
            end
            if (stalled && tx_data !== prev) bad++;
            if (tx_ch !== ch) bad++;
            if (tx_sop) begin
                if (tx_data !== hdr || ch_rd_en !== 3'b000 || tx_eop !== 1'b0) bad++;
            end else begin
                if (tx_valid !== 1'b1) bad++;
                if (tx_data !== fifo_word(ch, 16'(exp_head[ch]))) bad++;
                if (tx_eop !== (beat == len - 1)) bad++;
                if (ch_rd_en !== (tx_ready ? (3'b001 << ch) : 3'b000)) bad++;
                if (beat == pri_at && !pri_done) begin
                    PRI      = 1'b1;
                    pri_done = 1'b1;
                end
            end
            stalled = !tx_ready;
            prev    = tx_data;
            if (tx_ready && !tx_sop) begin
                exp_head[ch]++;
                beat++;
            end
            step();
        end
        chk("pkt_words",     64'(beat), 64'(len));
        chk("pkt_word_errs", 64'(bad),  64'd0);
        chk("pkt_pops",      head[ch] - head0, 16'(len));
        chk("pkt_gap",       tx_valid, 1'b0);
    endtask

    initial begin
        int n;
        int idle_hits;
        n_cmp = 0;
        n_bad = 0;
        toggle   = 1'b0;
        rst_n    = 1'b0;
        PRI      = 1'b0;
        tx_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            cnt[k]      = 10'd0;
            exp_head[k] = 0;
        end
        @(negedge clk_100M);
        @(negedge clk_100M);
        reset_checks("reset");

        // Four full packets, all channels eligible: ch0, ch1, ch2, ch0 with seq 0..3.
        cnt[0] = 10'd40; cnt[1] = 10'd40; cnt[2] = 10'd40;
        rst_n = 1'b1;
        wait_sop(10, n);
        chk("first_hdr_latency", 64'(n), 64'd2);
        run_pkt(2'd0, BL, 16'd0, 24'd0, -1, -1);
        wait_sop(10, n);
        chk("gap_one_cycle_a", 64'(n), 64'd1);
        run_pkt(2'd1, BL, 16'd0, 24'd1, -1, -1);
        wait_sop(10, n);
        chk("gap_one_cycle_b", 64'(n), 64'd1);
        run_pkt(2'd2, BL, 16'd0, 24'd2, -1, -1);
        wait_sop(10, n);
        chk("gap_one_cycle_c", 64'(n), 64'd1);
        run_pkt(2'd0, BL, 16'd0, 24'd3, -1, -1);

        // Only ch2 at exactly BURST_LEN; ch0 one short of it.
        rst_n = 1'b0;
        cnt[0] = 10'd31; cnt[1] = 10'd0; cnt[2] = 10'd32;
        @(negedge clk_100M);
        rst_n = 1'b1;
        wait_sop(10, n);
        chk("ch2_sel_bits", tx_data[53:52], 2'b10);
        chk("ch2_len_bits", tx_data[51:40], 12'd32);
        run_pkt(2'd2, BL, 16'd0, 24'd0, -1, -1);
        cnt[2] = 10'd0;
        idle_hits = 0;
        for (int i = 0; i < 5; i++) begin
            step();
            if (tx_valid !== 1'b0 || ch_rd_en !== 3'b000) idle_hits++;
        end
        chk("no_grant_below_burst", 64'(idle_hits), 64'd0);

        // Downstream stalls every other cycle.
        cnt[0] = 10'd0; cnt[1] = 10'd40;
        toggle = 1'b1;
        wait_sop(10, n);
        run_pkt(2'd1, BL, 16'd0, 24'd1, -1, -1);
        toggle   = 1'b0;
        tx_ready = 1'b1;

        // PRI mid-burst, then PRI coincident with eop.
        wait_sop(10, n);
        run_pkt(2'd1, BL, 16'd0, 24'd2, 10, -1);
        chk("frame_after_pri", frame_no, 16'd1);
        wait_sop(10, n);
        run_pkt(2'd1, BL, 16'd1, 24'd0, BL - 1, -1);
        chk("frame_after_pri_eop", frame_no, 16'd2);

        // Asynchronous reset at data word 10, then a clean restart.
        wait_sop(10, n);
        run_pkt(2'd1, BL, 16'd2, 24'd0, -1, 10);
        @(negedge clk_100M);
        rst_n = 1'b1;
        wait_sop(10, n);
        chk("restart_latency", 64'(n), 64'd2);
        run_pkt(2'd1, BL, 16'd0, 24'd0, -1, -1);
        cnt[1] = 10'd0;

`ifdef PARTIAL_FLUSH_EN
        // Residual words in ch0 flushed by a PRI edge as a short packet.
        cnt[0] = 10'd5;
        PRI    = 1'b1;
        wait_sop(10, n);
        chk("flush_latency", 64'(n), 64'd2);
        run_pkt(2'd0, 5, 16'd1, 24'd0, -1, -1);
        idle_hits = 0;
        for (int i = 0; i < 5; i++) begin
            step();
            if (tx_valid !== 1'b0) idle_hits++;
        end
        chk("flush_flag_cleared", 64'(idle_hits), 64'd0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
